sw_core_scheduler: RTL and testbench

- Shares one SW_core instance among NUM_REQ requesters; one job in flight at a time.
- Round-robin arbitration among requesters; rejects malformed jobs; routes each result back to its owner.
- Sits between the requester front-ends (DMA/pattern loaders) and SW_core; drives SW_core's i_valid/i_ready handshake exactly as SW_core expects.

---
 rtl/sw_sched_pkg.sv | 49 ++++
 rtl/sw_core_scheduler_arbiter.sv | 38 +++
 rtl/sw_core_scheduler.sv | 168 ++++++++++++++++
 tb/tb_sw_core_scheduler.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_sched_pkg.sv
// Shared types and sizes for the SW_core scheduler.
// Provides default values for the SW_core sizing macros when the build
// does not define them. Also defines the FSM state enum, the job and
// result records, and the job-length validity check.
`ifndef REF_MAX_LENGTH
`define REF_MAX_LENGTH 16
`endif
`ifndef READ_MAX_LENGTH
`define READ_MAX_LENGTH 8
`endif
`ifndef DP_SW_SCORE_BITWIDTH
`define DP_SW_SCORE_BITWIDTH 10
`endif

package sw_sched_pkg;

  localparam int REF_MAX    = `REF_MAX_LENGTH;
  localparam int READ_MAX   = `READ_MAX_LENGTH;
  localparam int SCORE_W    = `DP_SW_SCORE_BITWIDTH;
  localparam int REF_LEN_W  = $clog2(REF_MAX) + 1;
  localparam int READ_LEN_W = $clog2(READ_MAX) + 1;
  localparam int ROW_W      = $clog2(READ_MAX);
  localparam int COL_W      = $clog2(REF_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Sequences are 2 bits per base, MSB-aligned; lengths are 1-based.
  typedef struct packed {
    logic [2*REF_MAX-1:0]  ref_seq;
    logic [2*READ_MAX-1:0] read_seq;
    logic [REF_LEN_W-1:0]  ref_len;
    logic [READ_LEN_W-1:0] read_len;
  } job_t;

  typedef struct packed {
    logic signed [SCORE_W-1:0] score;
    logic [ROW_W-1:0]          row;
    logic [COL_W-1:0]          col;
    logic                      err;
  } result_t;

  // A job is runnable only if both lengths are in 1..MAX.
  function automatic logic len_ok(input logic [REF_LEN_W-1:0]  ref_len,
                                  input logic [READ_LEN_W-1:0] read_len);
    return (ref_len != '0) && (ref_len <= REF_LEN_W'(REF_MAX)) &&
           (read_len != '0) && (read_len <= READ_LEN_W'(READ_MAX));
  endfunction

endpackage

// File: rtl/sw_core_scheduler_arbiter.sv
// Round-robin arbiter (combinational).
// Ports:
//   req        - request vector
//   last_grant - index granted last; search starts just above it, with wrap
//   grant      - one-hot grant (zero when no request)
//   index      - binary index of the granted requester
//   any        - at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the search so no path through
    // the loop leaves a value unassigned, which would otherwise infer a latch.
    grant = '0;
    index = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = int'(last_grant) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[IDX_W'(k)]) begin
        any               = 1'b1;
        grant[IDX_W'(k)]  = 1'b1;
        index             = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sw_core_scheduler.sv
// Shares one SW_core among NUM_REQ requesters, one job in flight.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_ready         - per-requester job handshake (ready one-hot or zero)
//   req_ref/req_read            - packed per-requester sequences
//   req_ref_len/req_read_len    - packed per-requester 1-based lengths
//   res_valid/res_ready         - one-hot result handshake to the owner
//   res_score/row/col/err       - shared result bus; err marks a rejected job
//   core_o_ready/core_i_valid   - job strobe toward SW_core
//   core_seq_*/core_*_len       - job payload, non-zero only while issuing
//   core_i_ready/core_o_valid   - result handshake from SW_core
//   core_score/row/col          - SW_core result
//   jobs_done                   - completed jobs including rejected ones
//   last_latency                - core_i_valid to core_o_valid cycles, saturating
module sw_core_scheduler
  import sw_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*2*REF_MAX-1:0]       req_ref,
  input  logic [NUM_REQ*2*READ_MAX-1:0]      req_read,
  input  logic [NUM_REQ*REF_LEN_W-1:0]       req_ref_len,
  input  logic [NUM_REQ*READ_LEN_W-1:0]      req_read_len,
  output logic [NUM_REQ-1:0]                 res_valid,
  input  logic [NUM_REQ-1:0]                 res_ready,
  output logic signed [SCORE_W-1:0]          res_score,
  output logic [ROW_W-1:0]                   res_row,
  output logic [COL_W-1:0]                   res_col,
  output logic                               res_err,
  input  logic                               core_o_ready,
  output logic                               core_i_valid,
  output logic [2*REF_MAX-1:0]               core_seq_ref,
  output logic [2*READ_MAX-1:0]              core_seq_read,
  output logic [REF_LEN_W-1:0]               core_ref_len,
  output logic [READ_LEN_W-1:0]              core_read_len,
  output logic                               core_i_ready,
  input  logic                               core_o_valid,
  input  logic signed [SCORE_W-1:0]          core_score,
  input  logic [ROW_W-1:0]                   core_row,
  input  logic [COL_W-1:0]                   core_col,
  output logic [31:0]                        jobs_done,
  output logic [LAT_W-1:0]                   last_latency
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state;
  job_t                 sel_job;
  job_t                 core_job;
  result_t              res_q;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_any;
  logic                 accept;
  logic [LAT_W-1:0]     lat_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .index      (arb_idx),
    .any        (arb_any)
  );

  // Grant is offered only while idle and SW_core can take a job.
  assign accept    = (state == IDLE) && core_o_ready && arb_any;
  assign req_ready = accept ? arb_grant : '0;

  // Select the granted requester's payload out of the packed buses.
  always_comb begin
    sel_job = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_job.ref_seq  = req_ref[i*2*REF_MAX +: 2*REF_MAX];
        sel_job.read_seq = req_read[i*2*READ_MAX +: 2*READ_MAX];
        sel_job.ref_len  = req_ref_len[i*REF_LEN_W +: REF_LEN_W];
        sel_job.read_len = req_read_len[i*READ_LEN_W +: READ_LEN_W];
      end
    end
  end

  // core_job is only non-zero during ISSUE, so the payload bus is quiet
  // whenever core_i_valid is low.
  assign core_seq_ref  = core_job.ref_seq;
  assign core_seq_read = core_job.read_seq;
  assign core_ref_len  = core_job.ref_len;
  assign core_read_len = core_job.read_len;

  assign res_score = res_q.score;
  assign res_row   = res_q.row;
  assign res_col   = res_q.col;
  assign res_err   = res_q.err;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register is reset here, including payload and result
      // holding registers, so all outputs read zero right after reset and an
      // abandoned job leaves nothing behind.
      state        <= IDLE;
      core_job     <= '0;
      res_q        <= '0;
      owner        <= '0;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      lat_cnt      <= '0;
      last_latency <= '0;
      jobs_done    <= '0;
      res_valid    <= '0;
      core_i_valid <= 1'b0;
      core_i_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= arb_idx;
            if (len_ok(sel_job.ref_len, sel_job.read_len)) begin
              core_job     <= sel_job;
              core_i_valid <= 1'b1;
              state        <= ISSUE;
            end else begin
              // Malformed job: answer immediately, SW_core never sees it.
              res_q     <= '{score: '0, row: '0, col: '0, err: 1'b1};
              res_valid <= arb_grant;
              state     <= RESP;
            end
          end
        end
        ISSUE: begin
          core_i_valid <= 1'b0;
          core_job     <= '0;
          core_i_ready <= 1'b1;
          lat_cnt      <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (lat_cnt != '1) lat_cnt <= lat_cnt + LAT_W'(1);
          if (core_o_valid) begin
            res_q        <= '{score: core_score, row: core_row, col: core_col, err: 1'b0};
            // The counter lags the result by one cycle, hence the +1.
            last_latency <= (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);
            core_i_ready <= 1'b0;
            res_valid    <= NUM_REQ'(1) << owner;
            state        <= RESP;
          end
        end
        RESP: begin
          if (res_ready[owner]) begin
            res_valid  <= '0;
            res_q      <= '0;
            last_grant <= owner;
            jobs_done  <= jobs_done + 32'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_core_scheduler.sv
// Self-checking bench for sw_core_scheduler. A behavioural SW_core stub
// returns a result derived from the payload it receives; a transaction-level
// model predicts every output each cycle, and directed tests pin grant order,
// timing and boundary cases with literal values.
module tb_sw_core_scheduler;
  import sw_sched_pkg::*;

  localparam int N = 4;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [N-1:0]                  req_valid, req_ready, res_valid, res_ready;
  logic [N*2*REF_MAX-1:0]        req_ref;
  logic [N*2*READ_MAX-1:0]       req_read;
  logic [N*REF_LEN_W-1:0]        req_ref_len;
  logic [N*READ_LEN_W-1:0]       req_read_len;
  logic signed [SCORE_W-1:0]     res_score, core_score;
  logic [ROW_W-1:0]              res_row, core_row;
  logic [COL_W-1:0]              res_col, core_col;
  logic                          res_err;
  logic                          core_o_ready, core_i_valid, core_i_ready, core_o_valid;
  logic [2*REF_MAX-1:0]          core_seq_ref;
  logic [2*READ_MAX-1:0]         core_seq_read;
  logic [REF_LEN_W-1:0]          core_ref_len;
  logic [READ_LEN_W-1:0]         core_read_len;
  logic [31:0]                   jobs_done;
  logic [15:0]                   last_latency;

  job_t tb_job [N];

  sw_core_scheduler #(.NUM_REQ(N), .LAT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ref(req_ref), .req_read(req_read),
    .req_ref_len(req_ref_len), .req_read_len(req_read_len),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_score(res_score), .res_row(res_row), .res_col(res_col), .res_err(res_err),
    .core_o_ready(core_o_ready), .core_i_valid(core_i_valid),
    .core_seq_ref(core_seq_ref), .core_seq_read(core_seq_read),
    .core_ref_len(core_ref_len), .core_read_len(core_read_len),
    .core_i_ready(core_i_ready), .core_o_valid(core_o_valid),
    .core_score(core_score), .core_row(core_row), .core_col(core_col),
    .jobs_done(jobs_done), .last_latency(last_latency)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ref[i*2*REF_MAX +: 2*REF_MAX]        = tb_job[i].ref_seq;
      req_read[i*2*READ_MAX +: 2*READ_MAX]     = tb_job[i].read_seq;
      req_ref_len[i*REF_LEN_W +: REF_LEN_W]    = tb_job[i].ref_len;
      req_read_len[i*READ_LEN_W +: READ_LEN_W] = tb_job[i].read_len;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stand-in SW_core result: 3*ref_len - 2*read_len + top base of ref.
  function automatic result_t golden(input job_t j);
    result_t r;
    logic [1:0] top;
    top     = j.ref_seq[2*REF_MAX-1 -: 2];
    r.score = SCORE_W'(3*int'(j.ref_len) - 2*int'(j.read_len) + int'(top));
    r.row   = ROW_W'(int'(j.read_len) - 1);
    r.col   = COL_W'(int'(j.ref_len) - 1);
    r.err   = 1'b0;
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int s = 1; s <= N; s++) begin
      int k = (last + s) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  // ---------------- SW_core stub ----------------
  int      stub_delay = 1;
  int      stub_cnt   = 0;
  logic    spur       = 1'b0;
  logic    s_rst, s_iv;
  job_t    stub_job;
  result_t stub_r;

  initial begin
    core_o_valid = 1'b0;
    core_score   = '0;
    core_row     = '0;
    core_col     = '0;
    stub_job     = '0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_iv  = core_i_valid;
      if (s_iv) stub_job = '{ref_seq: core_seq_ref, read_seq: core_seq_read,
                             ref_len: core_ref_len, read_len: core_read_len};
      @(posedge clk);
      #1;
      core_o_valid = 1'b0;
      if (s_rst) begin
        stub_cnt = 0;
      end else begin
        if (s_iv) stub_cnt = stub_delay;
        if (stub_cnt > 0) begin
          stub_cnt--;
          if (stub_cnt == 0) begin
            stub_r       = golden(stub_job);
            core_o_valid = 1'b1;
            core_score   = stub_r.score;
            core_row     = stub_r.row;
            core_col     = stub_r.col;
          end
        end
        if (spur) begin
          core_o_valid = 1'b1;
          core_score   = SCORE_W'(77);
        end
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  bit      m_busy, m_issue, m_wait, m_resp;
  int      m_owner, m_last, m_jobs, m_lat, m_last_lat;
  job_t    m_job;
  result_t m_res;
  int      grant_log [$];
  int      resp_log  [$];
  int      mg;
  logic [N-1:0] exp_rr, exp_rv;
  job_t    exp_core;
  bit      m_bad;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_issue = 0; m_wait = 0; m_resp = 0;
      m_owner = 0; m_last = N - 1; m_jobs = 0; m_lat = 0; m_last_lat = 0;
      m_job = '0; m_res = '0;
    end else begin
      mg       = (!m_busy && core_o_ready) ? rr_pick(req_valid, m_last) : -1;
      exp_rr   = (mg >= 0) ? (N'(1) << mg) : '0;
      exp_core = m_issue ? m_job : '0;
      exp_rv   = m_resp ? (N'(1) << m_owner) : '0;
      check("req_ready", req_ready, exp_rr);
      check("core_i_valid", core_i_valid, m_issue);
      check("core_seq_ref", core_seq_ref, exp_core.ref_seq);
      check("core_seq_read", core_seq_read, exp_core.read_seq);
      check("core_ref_len", core_ref_len, exp_core.ref_len);
      check("core_read_len", core_read_len, exp_core.read_len);
      check("core_i_ready", core_i_ready, m_wait);
      check("res_valid", res_valid, exp_rv);
      if (m_resp) begin
        check("res_score", res_score, m_res.score);
        check("res_row", res_row, m_res.row);
        check("res_col", res_col, m_res.col);
        check("res_err", res_err, m_res.err);
      end
      check("jobs_done", jobs_done, m_jobs);
      check("last_latency", last_latency, m_last_lat);

      if (m_resp) begin
        if (res_ready[m_owner]) begin
          resp_log.push_back(m_owner);
          m_resp = 0; m_busy = 0; m_last = m_owner; m_jobs++;
        end
      end else if (m_wait) begin
        if (m_lat < 65535) m_lat++;
        if (core_o_valid) begin
          m_wait = 0; m_resp = 1;
          m_res = golden(m_job);
          m_last_lat = m_lat;
        end
      end else if (m_issue) begin
        m_issue = 0; m_wait = 1; m_lat = 0;
      end else if (mg >= 0) begin
        grant_log.push_back(mg);
        m_busy  = 1;
        m_owner = mg;
        m_job   = tb_job[mg];
        m_bad   = (m_job.ref_len == 0) || (int'(m_job.ref_len) > REF_MAX) ||
                  (m_job.read_len == 0) || (int'(m_job.read_len) > READ_MAX);
        if (m_bad) begin
          m_res = '0; m_res.err = 1'b1; m_resp = 1;
        end else begin
          m_issue = 1;
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for requester i's handshake; returns at posedge+1 after it.
  task automatic wait_accept(input int i);
    bit ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin
        ok = 1;
        break;
      end
    end
    check($sformatf("accept_seen_%0d", i), ok, 1);
    if (ok) check($sformatf("grant_onehot_%0d", i), req_ready, N'(1) << i);
    tick();
  endtask

  // Waits (at negedge) until some res_valid is high.
  task automatic wait_res();
    bit ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (res_valid != '0) begin
        ok = 1;
        break;
      end
    end
    check("res_seen", ok, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int base_g, base_r;
    bit ok;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_g, base_r;
    bit ok;
    req_valid    = '0;
    res_ready    = '1;
    core_o_ready = 1'b1;
    tb_job[0] = '{ref_seq: 32'h1234_5678, read_seq: 16'hA5A5, ref_len: 5'd10, read_len: 4'd5};
    tb_job[1] = '{ref_seq: 32'hC0DE_0001, read_seq: 16'h0F0F, ref_len: 5'd16, read_len: 4'd8};
    tb_job[2] = '{ref_seq: 32'h8BAD_F00D, read_seq: 16'h3C3C, ref_len: 5'd12, read_len: 4'd8};
    tb_job[3] = '{ref_seq: 32'h4000_0000, read_seq: 16'hC000, ref_len: 5'd1,  read_len: 4'd1};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_core_i_valid", core_i_valid, 0);
    check("rst_last_latency", last_latency, 0);

    // Single job from requester 2: score 36-16+2=22, row 7, col 11.
    tick();
    req_valid = 4'b0100;
    wait_accept(2);
    req_valid = '0;
    @(negedge clk);
    check("t1_issue_at_T1", core_i_valid, 1);
    wait_res();
    check("t1_res_valid", res_valid, 4'b0100);
    check("t1_score", res_score, 22);
    check("t1_row", res_row, 7);
    check("t1_col", res_col, 11);
    check("t1_latency", last_latency, 1);
    @(negedge clk);
    check("t1_jobs_done", jobs_done, 1);

    // Round-robin from reset: 0,1,2,3,0.
    tick();
    pulse_reset();
    stub_delay = 3;
    base_g = grant_log.size();
    base_r = resp_log.size();
    req_valid = 4'b1111;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (grant_log.size() >= base_g + 5) begin
        ok = 1;
        break;
      end
    end
    tick();
    req_valid = '0;
    check("rr_five_grants", ok, 1);
    for (int c = 0; c < 100 && resp_log.size() < base_r + 5; c++) @(negedge clk);
    check("rr_five_resps", resp_log.size() >= base_r + 5, 1);
    if (ok && resp_log.size() >= base_r + 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_grant_%0d", k), grant_log[base_g + k], k % N);
        check($sformatf("rr_resp_%0d", k), resp_log[base_r + k], k % N);
      end
    end
    @(negedge clk);
    check("rr_jobs_done", jobs_done, 5);

    // Bad length from requester 1: rejected at T+1.
    tick();
    stub_delay = 1;
    tb_job[1].ref_len = 5'd0;
    req_valid = 4'b0010;
    wait_accept(1);
    req_valid = '0;
    @(negedge clk);
    check("bad_res_valid", res_valid, 4'b0010);
    check("bad_err", res_err, 1);
    check("bad_score", res_score, 0);
    check("bad_no_issue", core_i_valid, 0);
    @(negedge clk);
    check("bad_jobs_done", jobs_done, 6);
    tb_job[1].ref_len = 5'd16;

    // Result backpressure on requester 3 while requester 0 waits.
    tick();
    res_ready = 4'b0111;
    req_valid = 4'b1001;
    wait_accept(3);
    req_valid = 4'b0001;
    wait_res();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_res_valid", res_valid, 4'b1000);
      check("bp_score", res_score, 2);
      check("bp_no_grant", req_ready, 0);
      check("bp_no_issue", core_i_valid, 0);
    end
    tick();
    res_ready = 4'b1111;
    wait_accept(0);
    req_valid = '0;
    wait_res();
    check("bp_next_owner", res_valid, 4'b0001);

    // Core not ready, plus a spurious core_o_valid while idle.
    tick();
    core_o_ready = 1'b0;
    req_valid    = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("cnr_no_grant", req_ready, 0);
    end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("spur_no_res", res_valid, 0);
      check("spur_no_wait", core_i_ready, 0);
    end
    tick();
    core_o_ready = 1'b1;
    wait_accept(1);
    req_valid = '0;
    wait_res();
    check("cnr_owner", res_valid, 4'b0010);

    // Reset while waiting on SW_core.
    tick();
    stub_delay = 10;
    req_valid = 4'b0100;
    wait_accept(2);
    req_valid = '0;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (core_i_ready) begin
        ok = 1;
        break;
      end
    end
    check("rw_reached_wait", ok, 1);
    tick();
    pulse_reset();
    @(negedge clk);
    check("rw_req_ready", req_ready, 0);
    check("rw_res_valid", res_valid, 0);
    check("rw_core_i_valid", core_i_valid, 0);
    check("rw_core_i_ready", core_i_ready, 0);
    check("rw_core_ref", core_seq_ref, 0);
    check("rw_jobs_done", jobs_done, 0);
    check("rw_latency", last_latency, 0);
    check("rw_score", res_score, 0);
    tick();
    stub_delay = 1;
    req_valid = 4'b1111;
    wait_accept(0);
    req_valid = '0;
    wait_res();
    check("rw_first_owner", res_valid, 4'b0001);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
